// File: rtl/status_register_unit.sv
// NZCV producer: flag generation, architectural status register and in-flight writer tracking.
// Optional exception shadow register enabled by defining STATUS_SHADOW_EN.
module status_register_unit #(
    parameter int WIDTH        = 32,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c,
    input  logic             alu_v,
    input  logic             alu_arith,
    input  logic             s_we,
    input  logic             msr_we,
    input  logic [3:0]       msr_data,
    input  logic             id_issue,
    input  logic             id_set_flags,
    input  logic [3:0]       id_cond,
    input  logic             flush,
    input  logic             exc_entry,
    input  logic             exc_return,
    output logic [3:0]       status_reg,
    output logic             flag_hazard
);

    localparam int PW = (MAX_INFLIGHT < 1) ? 1 : $clog2(MAX_INFLIGHT + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_INFLIGHT);
    localparam logic [3:0] COND_AL = 4'b1110;

    logic [PW-1:0] pend;
    logic          inc;
    logic          dec;
    logic [3:0]    s_flags;
    logic [3:0]    sr_wr;
    logic [3:0]    sr_next;

    assign flag_hazard = (pend != '0) && (id_cond != COND_AL);
    assign inc = id_issue & id_set_flags & ~flag_hazard;
    assign dec = s_we | msr_we;

    // Logical ops leave C and V untouched
    assign s_flags = {
        alu_result[WIDTH-1],
        alu_result == '0,
        alu_arith ? alu_c : status_reg[1],
        alu_arith ? alu_v : status_reg[0]
    };

    always_comb begin
        sr_wr = status_reg;
        if (msr_we)
            sr_wr = msr_data;
        else if (s_we)
            sr_wr = s_flags;
    end

`ifdef STATUS_SHADOW_EN
    logic [3:0] shadow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            shadow <= '0;
        else if (exc_entry)
            shadow <= status_reg;
    end

    assign sr_next = exc_return ? shadow : sr_wr;
`else
    logic unused_exc;

    assign unused_exc = exc_entry | exc_return;
    assign sr_next    = sr_wr;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            status_reg <= '0;
        else
            status_reg <= sr_next;
    end

    // Flush kills younger writers; an older commit in the same cycle still lands in SR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pend <= '0;
        else if (flush)
            pend <= '0;
        else if (inc && !dec && pend != PEND_MAX)
            pend <= pend + 1'b1;
        else if (dec && !inc && pend != '0)
            pend <= pend - 1'b1;
    end

endmodule

// File: tb/tb_status_register_unit.sv
// Self-checking bench for status_register_unit.
// Reference model tracks SR, shadow and pending count as plain integers.
module tb_status_register_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] alu_result = '0;
    logic        alu_c = 1'b0;
    logic        alu_v = 1'b0;
    logic        alu_arith = 1'b0;
    logic        s_we = 1'b0;
    logic        msr_we = 1'b0;
    logic [3:0]  msr_data = '0;
    logic        id_issue = 1'b0;
    logic        id_set_flags = 1'b0;
    logic [3:0]  id_cond = '0;
    logic        flush = 1'b0;
    logic        exc_entry = 1'b0;
    logic        exc_return = 1'b0;
    logic [3:0]  status_reg;
    logic        flag_hazard;

    int tests = 0;
    int fails = 0;

    status_register_unit #(.WIDTH(32), .MAX_INFLIGHT(3)) dut (
        .clk(clk), .rst(rst),
        .alu_result(alu_result), .alu_c(alu_c), .alu_v(alu_v),
        .alu_arith(alu_arith), .s_we(s_we),
        .msr_we(msr_we), .msr_data(msr_data),
        .id_issue(id_issue), .id_set_flags(id_set_flags),
        .id_cond(id_cond), .flush(flush),
        .exc_entry(exc_entry), .exc_return(exc_return),
        .status_reg(status_reg), .flag_hazard(flag_hazard)
    );

    always #5 clk = ~clk;

    // Model state
    logic [3:0] m_sr;
    logic [3:0] m_sh;
    int         m_pend;

    function automatic logic m_haz(int p, logic [3:0] c);
        return (p > 0) && (c != 4'd14);
    endfunction

    function automatic int clamp(int x);
        if (x < 0) return 0;
        if (x > 3) return 3;
        return x;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_sr   <= 4'd0;
            m_sh   <= 4'd0;
            m_pend <= 0;
        end else begin
`ifdef STATUS_SHADOW_EN
            if (exc_return)
                m_sr <= m_sh;
            else
`endif
            if (msr_we)
                m_sr <= msr_data;
            else if (s_we)
                m_sr <= {alu_result[31], alu_result == 32'd0,
                         alu_arith ? alu_c : m_sr[1],
                         alu_arith ? alu_v : m_sr[0]};
`ifdef STATUS_SHADOW_EN
            if (exc_entry)
                m_sh <= m_sr;
`endif
            if (flush)
                m_pend <= 0;
            else
                m_pend <= clamp(m_pend
                    + ((id_issue && id_set_flags && !m_haz(m_pend, id_cond)) ? 1 : 0)
                    - ((s_we || msr_we) ? 1 : 0));
        end
    end

    task automatic check(string name, logic [3:0] got, logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("model_sr", status_reg, m_sr);
            check("model_haz", {3'b0, flag_hazard}, {3'b0, m_haz(m_pend, id_cond)});
        end
    end

    task automatic idle();
        alu_result = '0; alu_c = 0; alu_v = 0; alu_arith = 0;
        s_we = 0; msr_we = 0; msr_data = '0;
        id_issue = 0; id_set_flags = 0; id_cond = 4'd14;
        flush = 0; exc_entry = 0; exc_return = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(logic [31:0] r, logic ar, logic c, logic v);
        idle();
        s_we = 1; alu_result = r; alu_arith = ar; alu_c = c; alu_v = v;
        tick();
    endtask

    task automatic issue_al();
        idle();
        id_issue = 1; id_set_flags = 1; id_cond = 4'd14;
        tick();
    endtask

    task automatic msr(logic [3:0] d);
        idle();
        msr_we = 1; msr_data = d;
        tick();
    endtask

    task automatic probe_haz(string name, logic exp);
        idle();
        id_cond = 4'b0001;
        #1;
        check(name, {3'b0, flag_hazard}, {3'b0, exp});
    endtask

    logic [3:0] exp_sr;

    initial begin
        idle();
        id_cond = 4'b0000;
        #22;
        check("reset_sr", status_reg, 4'b0000);
        check("reset_haz", {3'b0, flag_hazard}, 4'b0000);
        rst = 1;
        tick();

        commit(32'h0, 1, 1, 0);
        check("flags_zero_carry", status_reg, 4'b0110);
        commit(32'h8000_0000, 0, 0, 1);
        check("flags_logical_hold", status_reg, 4'b1010);

        // issue -> commit -> unstall
        issue_al();
        idle();
        id_cond = 4'b0000;
        s_we = 1; alu_result = 32'd5; alu_arith = 1;
        #1;
        check("haz_after_issue", {3'b0, flag_hazard}, 4'b0001);
        tick();
        check("sr_after_commit", status_reg, 4'b0000);
        probe_haz("haz_after_commit", 0);

        // simultaneous issue and retire
        issue_al();
        idle();
        id_issue = 1; id_set_flags = 1; id_cond = 4'd14;
        s_we = 1; alu_result = 32'd1;
        tick();
        probe_haz("haz_inc_dec", 1);
        commit(32'd2, 0, 0, 0);
        probe_haz("haz_inc_dec_clear", 0);

        // saturation at 3
        repeat (4) issue_al();
        probe_haz("haz_sat", 1);
        commit(32'd3, 0, 0, 0);
        commit(32'd4, 0, 0, 0);
        probe_haz("haz_sat_two_left", 1);
        commit(32'd5, 0, 0, 0);
        probe_haz("haz_sat_drained", 0);

        // flush with an older commit
        issue_al();
        issue_al();
        idle();
        flush = 1; s_we = 1; alu_result = 32'd0; alu_arith = 1; alu_v = 1;
        tick();
        check("flush_sr", status_reg, 4'b0101);
        probe_haz("flush_haz", 0);

        // msr and s_we together retire once
        issue_al();
        issue_al();
        idle();
        msr_we = 1; msr_data = 4'b1001; s_we = 1; alu_result = 32'd0;
        tick();
        check("msr_prio", status_reg, 4'b1001);
        probe_haz("msr_single_dec", 1);
        commit(32'd7, 1, 1, 1);
        check("msr_next_commit", status_reg, 4'b0011);
        probe_haz("msr_drained", 0);

        // exception shadow
        msr(4'b0101);
        idle(); exc_entry = 1; tick();
        msr(4'b1000);
        idle(); exc_return = 1; tick();
`ifdef STATUS_SHADOW_EN
        exp_sr = 4'b0101;
`else
        exp_sr = 4'b1000;
`endif
        check("exc_return", status_reg, exp_sr);
        msr(4'b0011);
        idle(); exc_entry = 1; tick();
        msr(4'b1100);
        idle(); exc_entry = 1; exc_return = 1; tick();
`ifdef STATUS_SHADOW_EN
        exp_sr = 4'b0011;
`else
        exp_sr = 4'b1100;
`endif
        check("exc_swap_sr", status_reg, exp_sr);
        idle(); exc_return = 1; tick();
        check("exc_swap_shadow", status_reg, 4'b1100);

        // asynchronous reset mid-operation
        issue_al();
        issue_al();
        idle();
        id_cond = 4'b0000;
        #2;
        rst = 0;
        #1;
        check("midreset_sr", status_reg, 4'b0000);
        check("midreset_haz", {3'b0, flag_hazard}, 4'b0000);
        tick();
        rst = 1;
        tick();
        probe_haz("post_reset_haz", 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/status_register_unit.md
# status_register_unit

Producer side of the NZCV condition flags. Computes N/Z/C/V from the EXE-stage ALU result, holds the architectural status register that feeds the ID-stage condition evaluation, and tracks in-flight flag-setting instructions so ID can stall conditional instructions until the flags they depend on are committed. It sits between the EXE stage, which writes it, and the ID stage, which reads `status_reg` and `flag_hazard`.

## Interface
- `WIDTH`, 32, ALU result width used for N/Z generation
- `MAX_INFLIGHT`, 3, maximum count of flag-setting instructions tracked between issue and commit (≥1)
- `clk` input 1 system clock, rising edge
- `rst` input 1 reset, asynchronous, active-low
- `alu_result` input WIDTH EXE-stage ALU result
- `alu_c`, `alu_v` input 1 each ALU carry-out and overflow
- `alu_arith` input 1 1 = arithmetic op (updates C,V); 0 = logical op (C,V held)
- `s_we` input 1 EXE commit of an S-suffixed instruction
- `msr_we` input 1 direct flag write
- `msr_data` input 4 {N,Z,C,V} for direct write
- `id_issue` input 1 ID stage issues an instruction this cycle
- `id_set_flags` input 1 issued instruction will write flags (S bit or MSR)
- `id_cond` input 4 condition field of the instruction in ID
- `flush` input 1 pipeline flush; kills all uncommitted younger instructions
- `exc_entry`, `exc_return` input 1 each save/restore the status register (see Configuration)
- `status_reg` output 4 {N,Z,C,V}, registered
- `flag_hazard` output 1 ID must stall this cycle

## Operation
- Flag generation on `s_we`: N = `alu_result[WIDTH-1]`; Z = (`alu_result` == 0); C = `alu_c`, V = `alu_v` when `alu_arith`=1, otherwise C,V keep their current values.
- SR next-value priority, highest first: `exc_return` (shadow) > `msr_we` (`msr_data`) > `s_we` (computed flags) > hold.
- Pending counter `pend`, range 0..MAX_INFLIGHT:
  - inc = `id_issue` & `id_set_flags` & ~`flag_hazard`; dec = `s_we` | `msr_we` (both high in one cycle is one retirement).
  - inc & dec: unchanged. dec at 0: stays 0. inc at MAX_INFLIGHT: saturates and holds.
  - `flush`: `pend` becomes 0, overriding inc and dec; a same-cycle `s_we`/`msr_we` still updates SR (the committing instruction is older than the flush).
- `flag_hazard` = (`pend` != 0) & (`id_cond` != 4'b1110). Combinational from registered `pend` and `id_cond`. An AL-condition instruction never stalls. A flag-setting AL instruction issues even while `pend` > 0.

## Timing
- Reset (`rst`=0, asynchronous): `status_reg`=4'b0000, `pend`=0, shadow=4'b0000, so `flag_hazard`=0.
- SR update latency is 1 cycle: flags written at edge k are visible on `status_reg` from edge k onward, so the ID consumer sees them the cycle after commit.
- `flag_hazard` falls in the cycle after the edge where the last pending writer commits. Typical issue→commit→unstall: ID issue at cycle t, EXE commit at t+1, dependent conditional proceeds at t+2.
- Reset asserted mid-operation clears everything immediately. In-flight writers are discarded; the upstream pipeline is reset together with this block.

## Configuration
- `STATUS_SHADOW_EN` defined: a 4-bit shadow register is present.
  - `exc_entry` copies the current `status_reg` (the pre-update value of that cycle) into the shadow.
  - `exc_return` loads the shadow into SR with top priority.
  - Entry and return in the same cycle swap the two values: SR takes the old shadow, shadow takes the old SR.
  - `exc_return` does not alter `pend`.
- `STATUS_SHADOW_EN` undefined: no shadow storage; `exc_entry` and `exc_return` are ignored, and SR priority starts at `msr_we`.

## Test plan
- Reset, then `s_we`=1, `alu_arith`=1, `alu_result`=0, `alu_c`=1, `alu_v`=0 -> `status_reg`=4'b0110 next cycle. Then `s_we` with `alu_arith`=0, `alu_result`=32'h8000_0000 -> 4'b1010 (C,V held).
- Issue a flag-setter (`id_issue`=`id_set_flags`=1, `id_cond`=4'b1110) at cycle 0; `id_cond`=4'b0000 at cycle 1 -> `flag_hazard`=1 at cycle 1; `s_we` at cycle 1 -> `flag_hazard`=0 at cycle 2.
- Issue and `s_we` in the same cycle with `pend`=1 -> `pend` stays 1 and `flag_hazard` stays 1 for `id_cond`=4'b0001. Issue 4 flag-setters with no commit -> `pend` saturates at 3.
- `pend`=2 with `flush` and `s_we` in the same cycle -> `pend`=0, SR takes the `s_we` flags, `flag_hazard`=0 next cycle.
- `msr_we`=1 with `msr_data`=4'b1001 together with `s_we` -> SR=4'b1001 and `pend` decrements by exactly 1.
- With `STATUS_SHADOW_EN`: SR=4'b0101, `exc_entry`; then SR written to 4'b1000; then `exc_return` -> SR=4'b0101. Entry and return in the same cycle -> swap. Without the macro -> SR unchanged.
